aes_subbytes_seq: RTL and testbench

//  Sequential SubBytes engine: takes one 128-bit AES state over a valid/ready handshake.

---
 rtl/aes_subbytes_seq_if.sv | 20 ++
 rtl/aes_subbytes_seq.sv | 136 +++++++++++++
 tb/tb_aes_subbytes_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_subbytes_seq_if.sv
// Valid/ready handshake bundle for the sequential SubBytes engine:
// one 128-bit state in, one substituted 128-bit state out.
interface aes_subbytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes of a latched 128-bit state per
// cycle through LANES combinational S-boxes, then presents the result until accepted.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_byte = SBOX[in_byte];
endmodule

module aes_subbytes_seq #(
   parameter int LANES = 4
) (
   input  logic                clk,
   input  logic                rst,
   aes_subbytes_seq_if.slave   bus,
   output logic                busy
);
   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [15:0][7:0]   work_q, work_d;
   logic [15:0][7:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [15:0][7:0]   sub_state;
   logic [4:0]         base;
   logic [3:0]         lane_pos [LANES];
   logic [7:0]         sb_out   [LANES];

   // Byte k of the state lives in packed slot 15-k (byte0 is the MSB).
   assign base = 5'(cnt_q) * 5'(LANES);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_pos[g] = 4'd15 - 4'(base + 5'(g));
      aes_sbox u_sbox (
         .in_byte  (work_q[lane_pos[g]]),
         .out_byte (sb_out[g])
      );
   end

   always_comb begin
      sub_state = work_q;
      for (int unsigned l = 0; l < LANES; l++) begin
         sub_state[lane_pos[l]] = sb_out[l];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.in_data;
               cnt_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            work_d = sub_state;
            if (cnt_q == CW'(BEATS - 1)) begin
               out_data_d  = sub_state;
               out_valid_d = 1'b1;
               state_d     = DONE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               busy_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Bench for aes_subbytes_seq: fixed vectors, handshake corner cases, reset abort,
// lane-count variants and random blocks against a GF(2^8) reference model.
module tb_aes_subbytes_seq;
   logic clk;
   logic rst;
   logic busy;
   int   tests;
   int   fails;

   aes_subbytes_seq_if tb_if ();

   aes_subbytes_seq #(.LANES(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (tb_if.slave),
      .busy (busy)
   );

   // Lane-count variants share one stimulus and always accept their result.
   logic         alt_in_valid;
   logic [127:0] alt_in_data;
   logic         alt_out_valid [4];
   logic [127:0] alt_out_data  [4];
   logic         alt_in_ready  [4];
   logic         alt_busy      [4];

   for (genvar g = 0; g < 4; g++) begin : g_alt
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      aes_subbytes_seq_if alt_if ();
      assign alt_if.in_valid  = alt_in_valid;
      assign alt_if.in_data   = alt_in_data;
      assign alt_if.out_ready = 1'b1;
      assign alt_out_valid[g] = alt_if.out_valid;
      assign alt_out_data[g]  = alt_if.out_data;
      assign alt_in_ready[g]  = alt_if.in_ready;
      aes_subbytes_seq #(.LANES(L)) u_alt (
         .clk  (clk),
         .rst  (rst),
         .bus  (alt_if.slave),
         .busy (alt_busy[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      logic [7:0] b;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      b = inv;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] subbytes_ref(input logic [127:0] s);
      logic [127:0] r = '0;
      for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = sbox_ref(s[127 - 8*k -: 8]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one block, wait for out_valid, hold it for 'hold' cycles, then take it.
   task automatic run_block(input logic [127:0] d, input int hold,
                            output logic [127:0] res, output int lat);
      tb_if.in_valid = 1'b1;
      tb_if.in_data  = d;
      tick();
      tb_if.in_valid = 1'b0;
      tb_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!tb_if.out_valid && lat < 64);
      res = tb_if.out_data;
      repeat (hold) tick();
      tb_if.out_ready = 1'b1;
      tick();
      tb_if.out_ready = 1'b0;
   endtask

   typedef struct {
      string        name;
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   localparam logic [127:0] V1_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V1_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

   initial begin
      vec_t         vecs [4];
      logic [127:0] res;
      logic [127:0] held;
      logic [127:0] rnd;
      int           lat;
      int           alt_lat [4];
      logic [127:0] alt_res [4];
      logic         saw;

      tests = 0;
      fails = 0;
      vecs[0] = '{"fips197", V1_IN, V1_OUT};
      vecs[1] = '{"zeros", '0, {16{8'h63}}};
      vecs[2] = '{"ones", '1, {16{8'h16}}};
      vecs[3] = '{"5a", {16{8'h5a}}, {16{8'hbe}}};

      rst = 1'b1;
      tb_if.in_valid = 1'b0;
      tb_if.in_data = '0;
      tb_if.out_ready = 1'b0;
      alt_in_valid = 1'b0;
      alt_in_data = '0;
      tick();
      tick();
      chk("rst_out_valid", 128'(tb_if.out_valid), 128'd0);
      chk("rst_out_data", tb_if.out_data, '0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_in_ready", 128'(tb_if.in_ready), 128'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 128'(tb_if.in_ready), 128'd1);

      for (int i = 0; i < 4; i++) begin
         run_block(vecs[i].din, i, res, lat);
         chk({vecs[i].name, "_data"}, res, vecs[i].dout);
         chk({vecs[i].name, "_latency"}, 128'(lat), 128'd4);
      end

      // Backpressure: result held for five cycles with the input side closed.
      tb_if.in_valid = 1'b1;
      tb_if.in_data  = V1_IN;
      tick();
      tb_if.in_valid = 1'b0;
      repeat (4) tick();
      chk("bp_valid_rise", 128'(tb_if.out_valid), 128'd1);
      held = tb_if.out_data;
      chk("bp_first_data", held, V1_OUT);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", 128'(tb_if.out_valid), 128'd1);
         chk("bp_out_data", tb_if.out_data, held);
         chk("bp_in_ready", 128'(tb_if.in_ready), 128'd0);
         chk("bp_busy", 128'(busy), 128'd1);
      end
      tb_if.out_ready = 1'b1;
      tick();
      tb_if.out_ready = 1'b0;
      chk("bp_valid_drop", 128'(tb_if.out_valid), 128'd0);
      chk("bp_in_ready_back", 128'(tb_if.in_ready), 128'd1);
      chk("bp_data_retained", tb_if.out_data, held);

      // A second block presented throughout RUN/DONE is taken only once IDLE.
      tb_if.in_valid = 1'b1;
      tb_if.in_data  = '0;
      tick();
      tb_if.in_data  = {16{8'h5a}};
      for (int i = 0; i < 3; i++) begin
         chk("hold_in_ready_run", 128'(tb_if.in_ready), 128'd0);
         chk("hold_data_kept", tb_if.out_data, held);
         tick();
      end
      tick();
      chk("hold_first_valid", 128'(tb_if.out_valid), 128'd1);
      chk("hold_first_data", tb_if.out_data, {16{8'h63}});
      tb_if.out_ready = 1'b1;
      tick();
      tb_if.out_ready = 1'b0;
      chk("hold_idle_in_ready", 128'(tb_if.in_ready), 128'd1);
      tick();
      tb_if.in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!tb_if.out_valid && lat < 64);
      chk("hold_second_latency", 128'(lat), 128'd4);
      chk("hold_second_data", tb_if.out_data, {16{8'hbe}});
      tb_if.out_ready = 1'b1;
      tick();
      tb_if.out_ready = 1'b0;

      // Reset at beat 2 aborts the block.
      tb_if.in_valid = 1'b1;
      tb_if.in_data  = {16{8'h11}};
      tick();
      tb_if.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("abort_in_ready_rst", 128'(tb_if.in_ready), 128'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", 128'(tb_if.out_valid), 128'd0);
      chk("abort_out_data", tb_if.out_data, '0);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_in_ready", 128'(tb_if.in_ready), 128'd1);
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tb_if.out_valid) saw = 1'b1;
      end
      chk("abort_no_valid", 128'(saw), 128'd0);
      run_block(V1_IN, 0, res, lat);
      chk("abort_next_data", res, V1_OUT);
      chk("abort_next_latency", 128'(lat), 128'd4);

      // Lane-count variants: same vector, latency 16/LANES.
      for (int g = 0; g < 4; g++) chk("alt_in_ready", 128'(alt_in_ready[g]), 128'd1);
      alt_in_valid = 1'b1;
      alt_in_data  = V1_IN;
      tick();
      alt_in_valid = 1'b0;
      alt_in_data  = '1;
      for (int g = 0; g < 4; g++) begin
         alt_lat[g] = 0;
         alt_res[g] = '0;
      end
      for (int c = 1; c <= 20; c++) begin
         tick();
         for (int g = 0; g < 4; g++) begin
            if (alt_out_valid[g] && alt_lat[g] == 0) begin
               alt_lat[g] = c;
               alt_res[g] = alt_out_data[g];
            end
         end
      end
      chk("lanes1_latency", 128'(alt_lat[0]), 128'd16);
      chk("lanes2_latency", 128'(alt_lat[1]), 128'd8);
      chk("lanes8_latency", 128'(alt_lat[2]), 128'd2);
      chk("lanes16_latency", 128'(alt_lat[3]), 128'd1);
      for (int g = 0; g < 4; g++) chk("lanes_data", alt_res[g], V1_OUT);

      // Random blocks against the GF(2^8) model.
      for (int i = 0; i < 12; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         run_block(rnd, int'($urandom_range(0, 3)), res, lat);
         chk("rand_data", res, subbytes_ref(rnd));
         chk("rand_latency", 128'(lat), 128'd4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
